// File: rtl/seg7_scan_driver_if.sv
// Display-side bus of the seven-segment scan driver: value/enable/decimal-point
// load strobe in, multiplexed anode/segment drive and frame pulse out.
interface seg7_scan_driver_if;
  logic [15:0] VALUE;
  logic [3:0]  DIGIT_EN;
  logic [3:0]  DP;
  logic        LOAD;
  logic [3:0]  AN;
  logic [6:0]  SEG;
  logic        DP_N;
  logic        FRAME_TICK;

  modport master (
    output VALUE, DIGIT_EN, DP, LOAD,
    input  AN, SEG, DP_N, FRAME_TICK
  );

  modport slave (
    input  VALUE, DIGIT_EN, DP, LOAD,
    output AN, SEG, DP_N, FRAME_TICK
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode hex display driver with per-digit
// blanking before each lit slot and a once-per-frame double-buffered update.
module seg7_scan_driver #(
  parameter int frequency    = 100_000_000,
  parameter int refresh_rate = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic              CLK,
  input  logic              RESET,
  seg7_scan_driver_if.slave bus
);
  localparam int DIGIT_CYCLES = frequency / (refresh_rate * 4);
  localparam int CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);

  generate
    if (!(DIGIT_CYCLES > BLANK_CYCLES && BLANK_CYCLES >= 1)) begin : g_param_check
      $error("seg7_scan_driver: need DIGIT_CYCLES > BLANK_CYCLES >= 1");
    end
  endgenerate

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_idx;
  logic [23:0]     r_shadow;  // {VALUE, DIGIT_EN, DP}
  logic [23:0]     r_disp;
  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic            r_dp_n;
  logic            r_frame_tick;

  state_t          w_state_next;
  logic [CW-1:0]   w_cnt_next;
  logic [1:0]      w_idx_next;
  logic [23:0]     w_shadow_next;
  logic [23:0]     w_disp_next;
  logic [3:0]      w_an_next;
  logic [6:0]      w_seg_next;
  logic            w_dp_n_next;
  logic            w_tick_next;
  logic [3:0]      w_nib [4];
  logic [3:0]      w_en;
  logic [3:0]      w_dp;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      assign w_nib[gi] = w_disp_next[8 + 4*gi +: 4];
    end
  endgenerate

  assign w_en = w_disp_next[7:4];
  assign w_dp = w_disp_next[3:0];

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + CW'(1);
    w_idx_next    = r_idx;
    w_disp_next   = r_disp;
    w_tick_next   = 1'b0;
    w_shadow_next = bus.LOAD ? {bus.VALUE, bus.DIGIT_EN, bus.DP} : r_shadow;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_next = ST_SHOW;
          // Frame-boundary swap uses the shadow as it stood before this edge.
          if (r_idx == 2'd0) w_disp_next = r_shadow;
        end
      end
      ST_SHOW: begin
        if (r_cnt == DIGIT_LAST) begin
          w_cnt_next   = '0;
          w_idx_next   = r_idx + 2'd1;
          w_state_next = ST_BLANK;
          w_tick_next  = (r_idx == 2'd3);
        end
      end
    endcase
  end

  // Outputs are decoded from next-state so they switch on the transition edge.
  always_comb begin
    w_an_next   = 4'hF;
    w_seg_next  = 7'h7F;
    w_dp_n_next = 1'b1;
    if (w_state_next == ST_SHOW && w_en[w_idx_next]) begin
      w_an_next   = ~(4'b0001 << w_idx_next);
      w_seg_next  = hex_to_seg(w_nib[w_idx_next]);
      w_dp_n_next = ~w_dp[w_idx_next];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= ST_BLANK;
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= '0;
      r_disp       <= '0;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp_n       <= 1'b1;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_idx        <= w_idx_next;
      r_shadow     <= w_shadow_next;
      r_disp       <= w_disp_next;
      r_an         <= w_an_next;
      r_seg        <= w_seg_next;
      r_dp_n       <= w_dp_n_next;
      r_frame_tick <= w_tick_next;
    end
  end

  assign bus.AN         = r_an;
  assign bus.SEG        = r_seg;
  assign bus.DP_N       = r_dp_n;
  assign bus.FRAME_TICK = r_frame_tick;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver; a time-since-reset model predicts
// every output each cycle and checks anode exclusivity and blanking gaps.
module tb_seg7_scan_driver;
  localparam int FREQ  = 4000;
  localparam int RR    = 100;
  localparam int BLANK = 2;
  localparam int DIGIT = 10;
  localparam int FRAME = 40;
  localparam logic [6:0] HEX_TAB [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_driver_if bus();

  seg7_scan_driver #(
    .frequency(FREQ),
    .refresh_rate(RR),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .CLK(clk),
    .RESET(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_t = 0;
  logic [23:0] m_shadow = '0;
  logic [23:0] m_disp = '0;
  bit          m_valid = 1'b0;
  int          off_run = 0;
  bit          strict = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model from pre-edge inputs, then compare outputs.
  task automatic cycle(input string tag);
    logic [3:0] prev_an;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       e_tick;
    int         p;
    int         d;
    prev_an = bus.AN;
    @(posedge clk);
    if (rst) begin
      m_t = 0; m_shadow = '0; m_disp = '0; m_valid = 1'b1;
    end else begin
      m_t++;
      if (m_t % FRAME == BLANK) m_disp = m_shadow;
      if (bus.LOAD) m_shadow = {bus.VALUE, bus.DIGIT_EN, bus.DP};
    end
    #1;
    if (!m_valid) return;
    p = m_t % FRAME;
    d = p / DIGIT;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    e_tick = (m_t > 0 && p == 0);
    if (p % DIGIT >= BLANK && m_disp[4 + d]) begin
      e_an  = ~(4'b0001 << d);
      e_seg = HEX_TAB[m_disp[8 + 4*d +: 4]];
      e_dp  = ~m_disp[d];
    end
    check({tag, "/AN"}, 32'(bus.AN), 32'(e_an));
    check({tag, "/SEG"}, 32'(bus.SEG), 32'(e_seg));
    check({tag, "/DP_N"}, 32'(bus.DP_N), 32'(e_dp));
    check({tag, "/TICK"}, 32'(bus.FRAME_TICK), 32'(e_tick));
    check({tag, "/onehot"}, 32'($countones(~bus.AN) <= 1), 32'd1);
    if (prev_an == 4'hF && bus.AN != 4'hF) begin
      check({tag, "/gap_min"}, 32'(off_run >= BLANK), 32'd1);
      if (strict) check({tag, "/gap_exact"}, 32'(off_run), 32'(BLANK));
    end
    if (bus.AN == 4'hF) off_run++;
    else off_run = 0;
  endtask

  task automatic load(input string tag, input logic [15:0] v, input logic [3:0] en, input logic [3:0] dp);
    bus.VALUE = v; bus.DIGIT_EN = en; bus.DP = dp; bus.LOAD = 1'b1;
    cycle(tag);
    bus.LOAD = 1'b0;
    bus.VALUE = 16'($urandom); bus.DIGIT_EN = 4'($urandom); bus.DP = 4'($urandom);
  endtask

  // Run until the model sits at frame position pos (bounded to two frames).
  task automatic wait_pos(input string tag, input int pos);
    for (int i = 0; i < 2*FRAME && (m_t % FRAME) != pos; i++) cycle(tag);
  endtask

  initial begin
    bus.VALUE = '0; bus.DIGIT_EN = '0; bus.DP = '0; bus.LOAD = 1'b0;
    rst = 1'b1;
    cycle("rst");
    cycle("rst");
    rst = 1'b0;

    repeat (80) cycle("idle");

    load("p2_load", 16'h1A3F, 4'b1111, 4'b0100);
    repeat (80) cycle("p2");

    load("p3_load", 16'h8888, 4'b0011, 4'b0000);
    repeat (80) cycle("p3");

    wait_pos("p4_wait", 12);
    load("p4_load0", 16'h0000, 4'b1111, 4'b0000);
    repeat (3) cycle("p4");
    load("p4_loadF", 16'hFFFF, 4'b1111, 4'b0000);
    repeat (60) cycle("p4");
    wait_pos("p4_wait", 1);
    load("p4_edge", 16'h5A5A, 4'b1111, 4'b1010);
    repeat (80) cycle("p4_defer");

    wait_pos("p5_wait", 25);
    rst = 1'b1;
    cycle("p5_rst");
    rst = 1'b0;
    repeat (80) cycle("p5");

    load("p6_load", 16'($urandom), 4'b1111, 4'($urandom));
    repeat (80) cycle("p6_pre");
    strict = 1'b1;
    repeat (10 * FRAME) begin
      bus.LOAD = ($urandom_range(15) == 0);
      bus.VALUE = 16'($urandom); bus.DIGIT_EN = 4'b1111; bus.DP = 4'($urandom);
      cycle("p6");
    end
    strict = 1'b0;

    repeat (5 * FRAME) begin
      bus.LOAD = ($urandom_range(7) == 0);
      bus.VALUE = 16'($urandom); bus.DIGIT_EN = 4'($urandom); bus.DP = 4'($urandom);
      cycle("p7");
    end
    bus.LOAD = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
